// File: rtl/cache_line_controller_pkg.sv
// Shared types and address helpers for the direct-mapped write-back cache controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cache_pkg;

  // Per-line state as held by the tag unit.
  typedef enum logic [1:0] {
    INVALID  = 2'd0,
    VALID    = 2'd1,
    MODIFIED = 2'd2
  } line_state_t;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COMPARE   = 3'd1,
    WRITEBACK = 3'd2,
    FILL      = 3'd3,
    COMPLETE  = 3'd4
  } controller_state_t;

  // Extract a width-bit field starting at bit lsb of an address (addresses up to 32 bits).
  function automatic logic [31:0] addr_field(input logic [31:0] addr, input int lsb, input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (addr >> lsb) & mask;
  endfunction

  // Word offset within the line: lowest field of {tag, index, offset}.
  function automatic logic [31:0] offset_of(input logic [31:0] addr, input int offset_w);
    return addr_field(addr, 0, offset_w);
  endfunction

  // Line index: sits directly above the offset.
  function automatic logic [31:0] index_of(input logic [31:0] addr, input int offset_w, input int index_w);
    return addr_field(addr, offset_w, index_w);
  endfunction

  // Tag: everything above offset and index.
  function automatic logic [31:0] tag_of(input logic [31:0] addr, input int offset_w, input int index_w,
                                         input int tag_w);
    return addr_field(addr, offset_w + index_w, tag_w);
  endfunction

endpackage

// File: rtl/cache_line_controller_if.sv
// Word-wide memory bus between the cache controller (master) and backing memory (slave).
// Latency: one mem_ack per word, arbitrary delay; no timeout.
// Backpressure: master holds address, data and strobe stable until mem_ack.
interface cache_line_controller_if #(
  parameter int ADDRESS_WIDTH = 14,
  parameter int DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-1:0] mem_address;
  logic                     mem_read;
  logic                     mem_write;
  logic [DATA_WIDTH-1:0]    mem_write_data;
  logic [DATA_WIDTH-1:0]    mem_read_data;
  logic                     mem_ack;

  modport master (
    output mem_address, mem_read, mem_write, mem_write_data,
    input  mem_read_data, mem_ack
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_write_data,
    output mem_read_data, mem_ack
  );
endinterface

// File: rtl/cache_line_controller_counter.sv
// Word counter shared by write-back and fill bursts; wraps after the last word of a line.
// Latency: count updates on the clock edge following clear/increment.
// Backpressure: advances only on incr_i (a memory acknowledge), otherwise holds.
module line_transfer_counter #(
  parameter int OFFSET_WIDTH = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear_i,
  input  logic                    incr_i,
  output logic [OFFSET_WIDTH-1:0] count_o,
  output logic                    last_word_o
);

  logic [OFFSET_WIDTH-1:0] count_q;
  logic [OFFSET_WIDTH-1:0] count_d;

  // Next count: clear wins, then increment (natural wrap to 0 after the last word).
  always_comb begin
    count_d = count_q;
    if (reset || clear_i) begin
      count_d = '0;
    end else if (incr_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    count_q <= count_d;
  end

  assign count_o     = count_q;
  assign last_word_o = &count_q;

endmodule

// File: rtl/cache_line_controller.sv
// Direct-mapped write-back cache controller: sequences CPU requests, dirty write-back and line fill.
// Latency: hit completes 2 cycles after acceptance; miss adds write-back words, 4 fill words and a re-compare.
// Backpressure: every bus word waits on mem_ack with stable outputs; CPU requests are ignored outside IDLE.
module cache_line_controller
  import cache_pkg::*;
#(
  parameter int TAG_WIDTH    = 8,
  parameter int INDEX_WIDTH  = 4,
  parameter int OFFSET_WIDTH = 2,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] cpu_address,
  input  logic                                      cpu_read,
  input  logic                                      cpu_write,
  input  logic [DATA_WIDTH-1:0]                     cpu_write_data,
  output logic [DATA_WIDTH-1:0]                     cpu_read_data,
  output logic                                      cpu_complete,
  output logic [INDEX_WIDTH-1:0]                    line_index,
  output logic [TAG_WIDTH-1:0]                      tag_in,
  input  logic [TAG_WIDTH-1:0]                      tag_out,
  input  logic [1:0]                                state_out,
  input  logic                                      tag_hit,
  output logic                                      write_tag,
  output logic [1:0]                                state_in,
  output logic                                      write_state,
  output logic [OFFSET_WIDTH-1:0]                   data_offset,
  output logic                                      data_write,
  output logic [DATA_WIDTH-1:0]                     data_write_value,
  input  logic [DATA_WIDTH-1:0]                     data_read_value,
  cache_line_controller_if.master                   mem_bus
);

  localparam int ADDRESS_WIDTH = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH;

  controller_state_t        state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] req_address_q, req_address_d;
  logic [DATA_WIDTH-1:0]    req_data_q, req_data_d;
  logic                     req_write_q, req_write_d;
  logic [DATA_WIDTH-1:0]    read_data_q, read_data_d;

  logic [TAG_WIDTH-1:0]     req_tag;
  logic [INDEX_WIDTH-1:0]   req_index;
  logic [OFFSET_WIDTH-1:0]  req_offset;

  logic [OFFSET_WIDTH-1:0]  word_count;
  logic                     last_word;
  logic                     count_clear;
  logic                     count_incr;

  logic [ADDRESS_WIDTH-1:0] bus_address;
  logic                     bus_read;
  logic                     bus_write;
  logic [DATA_WIDTH-1:0]    bus_wdata;

  assign req_tag    = TAG_WIDTH'(tag_of(32'(req_address_q), OFFSET_WIDTH, INDEX_WIDTH, TAG_WIDTH));
  assign req_index  = INDEX_WIDTH'(index_of(32'(req_address_q), OFFSET_WIDTH, INDEX_WIDTH));
  assign req_offset = OFFSET_WIDTH'(offset_of(32'(req_address_q), OFFSET_WIDTH));

  // Counter is zeroed whenever a compare happens so every burst starts at word 0.
  assign count_clear = (state_q == COMPARE);
  assign count_incr  = mem_bus.mem_ack && ((state_q == WRITEBACK) || (state_q == FILL));

  line_transfer_counter #(
    .OFFSET_WIDTH (OFFSET_WIDTH)
  ) u_counter (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (count_clear),
    .incr_i      (count_incr),
    .count_o     (word_count),
    .last_word_o (last_word)
  );

  // Tag unit always sees the latched request's index and tag.
  assign line_index    = req_index;
  assign tag_in        = req_tag;
  assign cpu_read_data = read_data_q;

  assign mem_bus.mem_address    = bus_address;
  assign mem_bus.mem_read       = bus_read;
  assign mem_bus.mem_write      = bus_write;
  assign mem_bus.mem_write_data = bus_wdata;

  // Next-state, request latching and per-state strobes; reset overrides everything last.
  always_comb begin
    state_d          = state_q;
    req_address_d    = req_address_q;
    req_data_d       = req_data_q;
    req_write_d      = req_write_q;
    read_data_d      = read_data_q;
    cpu_complete     = 1'b0;
    write_tag        = 1'b0;
    write_state      = 1'b0;
    state_in         = INVALID;
    data_offset      = req_offset;
    data_write       = 1'b0;
    data_write_value = req_data_q;
    bus_address      = {req_tag, req_index, word_count};
    bus_read         = 1'b0;
    bus_write        = 1'b0;
    bus_wdata        = data_read_value;

    case (state_q)
      IDLE: begin
        if (cpu_read || cpu_write) begin
          req_address_d = cpu_address;
          req_data_d    = cpu_write_data;
          req_write_d   = cpu_write;   // a simultaneous read+write is treated as a write
          state_d       = COMPARE;
        end
      end

      COMPARE: begin
        if (tag_hit) begin
          if (req_write_q) begin
            data_write  = 1'b1;
            write_state = 1'b1;
            state_in    = MODIFIED;
          end else begin
            read_data_d = data_read_value;
          end
          state_d = COMPLETE;
        end else if (line_state_t'(state_out) == MODIFIED) begin
          state_d = WRITEBACK;
        end else begin
          state_d = FILL;
        end
      end

      WRITEBACK: begin
        // Victim address is rebuilt from the tag currently stored at this index.
        bus_write   = 1'b1;
        bus_address = {tag_out, req_index, word_count};
        data_offset = word_count;
        bus_wdata   = data_read_value;
        if (mem_bus.mem_ack && last_word) begin
          state_d = FILL;
        end
      end

      FILL: begin
        bus_read    = 1'b1;
        data_offset = word_count;
        if (mem_bus.mem_ack) begin
          data_write       = 1'b1;
          data_write_value = mem_bus.mem_read_data;
          if (last_word) begin
            // Tag and state are committed only once the whole line is present.
            write_tag   = 1'b1;
            write_state = 1'b1;
            state_in    = VALID;
            state_d     = COMPARE;
          end
        end
      end

      COMPLETE: begin
        cpu_complete = 1'b1;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (reset) begin
      state_d       = IDLE;
      req_address_d = '0;
      req_data_d    = '0;
      req_write_d   = 1'b0;
      read_data_d   = '0;
      cpu_complete  = 1'b0;
      write_tag     = 1'b0;
      write_state   = 1'b0;
      data_write    = 1'b0;
      bus_read      = 1'b0;
      bus_write     = 1'b0;
    end
  end

  // Controller state and latched request registers.
  always_ff @(posedge clock) begin
    state_q       <= state_d;
    req_address_q <= req_address_d;
    req_data_q    <= req_data_d;
    req_write_q   <= req_write_d;
    read_data_q   <= read_data_d;
  end

endmodule

// File: tb/tb_cache_line_controller.sv
// Bench: tag unit, data array and memory models around the controller, checked against a line-level cache model.
// Latency: n/a.
// Backpressure: memory responder acks each word after ack_delay idle cycles.
module tb_cache_line_controller;
  import cache_pkg::*;

  typedef struct {
    logic [13:0] addr;
    logic        wr;
    logic [31:0] data;
  } xact_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] cpu_address = '0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [31:0] cpu_write_data = '0;
  logic [31:0] cpu_read_data;
  logic        cpu_complete;
  logic [3:0]  line_index;
  logic [7:0]  tag_in;
  logic [7:0]  tag_out;
  logic [1:0]  state_out;
  logic        tag_hit;
  logic        write_tag;
  logic [1:0]  state_in;
  logic        write_state;
  logic [1:0]  data_offset;
  logic        data_write;
  logic [31:0] data_write_value;
  logic [31:0] data_read_value;

  cache_line_controller_if #(.ADDRESS_WIDTH(14), .DATA_WIDTH(32)) bus ();

  cache_line_controller dut (
    .clock            (clock),
    .reset            (reset),
    .cpu_address      (cpu_address),
    .cpu_read         (cpu_read),
    .cpu_write        (cpu_write),
    .cpu_write_data   (cpu_write_data),
    .cpu_read_data    (cpu_read_data),
    .cpu_complete     (cpu_complete),
    .line_index       (line_index),
    .tag_in           (tag_in),
    .tag_out          (tag_out),
    .state_out        (state_out),
    .tag_hit          (tag_hit),
    .write_tag        (write_tag),
    .state_in         (state_in),
    .write_state      (write_state),
    .data_offset      (data_offset),
    .data_write       (data_write),
    .data_write_value (data_write_value),
    .data_read_value  (data_read_value),
    .mem_bus          (bus.master)
  );

  always #5 clock = ~clock;

  // Environment: tag unit, data array, backing memory.
  logic [7:0]  tag_mem [16];
  logic [1:0]  st_mem  [16];
  logic [31:0] data_arr [64];
  logic [31:0] mem [16384];
  int          wt_count = 0;
  int          ack_delay = 0;
  xact_t       bus_log [$];
  logic [13:0] rd_trace [$];

  // Reference model: CPU-visible memory plus per-line tag/valid/dirty.
  logic [31:0] gold [16384];
  logic [7:0]  ctag [16];
  bit          cvalid [16];
  bit          cdirty [16];
  logic [31:0] last_read = '0;

  int n_checks = 0;
  int n_fails  = 0;

  assign tag_out         = tag_mem[line_index];
  assign state_out       = st_mem[line_index];
  assign tag_hit         = (st_mem[line_index] != 2'd0) && (tag_mem[line_index] == tag_in);
  assign data_read_value = data_arr[{line_index, data_offset}];

  always @(posedge clock) begin
    if (write_tag) wt_count <= wt_count + 1;
    if (reset) begin
      for (int i = 0; i < 16; i++) st_mem[i] <= 2'd0;
    end else begin
      if (write_tag)   tag_mem[line_index] <= tag_in;
      if (write_state) st_mem[line_index]  <= state_in;
      if (data_write)  data_arr[{line_index, data_offset}] <= data_write_value;
    end
  end

  initial begin : responder
    int    wait_cnt;
    xact_t x;
    wait_cnt = 0;
    bus.mem_ack = 1'b0;
    bus.mem_read_data = '0;
    forever begin
      @(negedge clock);
      if (!reset && (bus.mem_read || bus.mem_write)) begin
        if (wait_cnt >= ack_delay) begin
          bus.mem_ack = 1'b1;
          wait_cnt = 0;
          x.addr = bus.mem_address;
          x.wr   = bus.mem_write;
          if (bus.mem_write) begin
            x.data = bus.mem_write_data;
            mem[bus.mem_address] = bus.mem_write_data;
          end else begin
            x.data = mem[bus.mem_address];
            bus.mem_read_data = mem[bus.mem_address];
          end
          bus_log.push_back(x);
        end else begin
          bus.mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        bus.mem_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // Issue one request, predict its bus traffic, latency and result from the line model, and check them.
  task automatic run_req(input logic [13:0] addr, input logic wr, input logic [31:0] data);
    logic [7:0]  tg;
    logic [3:0]  idx;
    logic [13:0] a;
    bit          hit;
    bit          evict;
    int          exp_lat;
    int          cycles;
    bit          done;
    xact_t       exp_q [$];
    xact_t       x;
    tg  = addr[13:6];
    idx = addr[5:2];
    hit   = cvalid[idx] && (ctag[idx] == tg);
    evict = !hit && cvalid[idx] && cdirty[idx];
    if (evict) begin
      for (int w = 0; w < 4; w++) begin
        a = {ctag[idx], idx, w[1:0]};
        x.addr = a; x.wr = 1'b1; x.data = gold[a];
        exp_q.push_back(x);
      end
    end
    if (!hit) begin
      for (int w = 0; w < 4; w++) begin
        a = {tg, idx, w[1:0]};
        x.addr = a; x.wr = 1'b0; x.data = gold[a];
        exp_q.push_back(x);
      end
      ctag[idx]   = tg;
      cvalid[idx] = 1'b1;
      cdirty[idx] = 1'b0;
    end
    exp_lat = hit ? 2 : 2 + ((evict ? 4 : 0) + 4) * (ack_delay + 1) + 1;
    if (wr) begin
      gold[addr]  = data;
      cdirty[idx] = 1'b1;
    end else begin
      last_read = gold[addr];
    end

    bus_log.delete();
    rd_trace.delete();
    cpu_address    = addr;
    cpu_read       = !wr;
    cpu_write      = wr;
    cpu_write_data = data;
    cycles = 0;
    done   = 1'b0;
    while (!done && cycles < 400) begin
      step();
      cycles++;
      if (bus.mem_read) rd_trace.push_back(bus.mem_address);
      if (cpu_complete === 1'b1) done = 1'b1;
    end
    cpu_read  = 1'b0;
    cpu_write = 1'b0;

    n_checks++;
    if (!done) begin
      n_fails++;
      $display("FAIL req_timeout addr=%h: no cpu_complete within %0d cycles", addr, cycles);
    end else begin
      n_checks++;
      if (cycles != exp_lat) begin
        n_fails++;
        $display("FAIL latency addr=%h: got %0d cycles expected %0d", addr, cycles, exp_lat);
      end
      n_checks++;
      if (cpu_read_data !== last_read) begin
        n_fails++;
        $display("FAIL read_data addr=%h: got %h expected %h", addr, cpu_read_data, last_read);
      end
    end
    n_checks++;
    if (bus_log.size() != exp_q.size()) begin
      n_fails++;
      $display("FAIL bus_count addr=%h: got %0d words expected %0d", addr, bus_log.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < bus_log.size(); i++) begin
      n_checks++;
      if (bus_log[i].addr !== exp_q[i].addr || bus_log[i].wr !== exp_q[i].wr || bus_log[i].data !== exp_q[i].data) begin
        n_fails++;
        $display("FAIL bus_word%0d: got a=%h w=%b d=%h expected a=%h w=%b d=%h", i, bus_log[i].addr,
                 bus_log[i].wr, bus_log[i].data, exp_q[i].addr, exp_q[i].wr, exp_q[i].data);
      end
    end
    n_checks++;
    if (tag_mem[idx] !== tg || st_mem[idx] !== (cdirty[idx] ? 2'd2 : 2'd1)) begin
      n_fails++;
      $display("FAIL tag_state idx=%0d: got tag=%h st=%0d expected tag=%h st=%0d", idx, tag_mem[idx],
               st_mem[idx], tg, cdirty[idx] ? 2 : 1);
    end
    step();
    n_checks++;
    if (cpu_complete !== 1'b0) begin
      n_fails++;
      $display("FAIL complete_pulse addr=%h: got %b expected 0 one cycle after completion", addr, cpu_complete);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    cpu_read = 1'b1;
    cpu_address = 14'h0123;
    repeat (3) step();
    n_checks++;
    if ({cpu_complete, write_tag, write_state, data_write, bus.mem_read, bus.mem_write} !== 6'b0) begin
      n_fails++;
      $display("FAIL reset_strobes: got %b expected 000000",
               {cpu_complete, write_tag, write_state, data_write, bus.mem_read, bus.mem_write});
    end
    reset    = 1'b0;
    cpu_read = 1'b0;
    bus_log.delete();
    repeat (3) step();
    n_checks++;
    if (cpu_read_data !== 32'h0) begin
      n_fails++;
      $display("FAIL reset_read_data: got %h expected 0", cpu_read_data);
    end
    n_checks++;
    if (bus_log.size() != 0 || bus.mem_read !== 1'b0 || cpu_complete !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_idle: got %0d bus words, mem_read=%b complete=%b expected none",
               bus_log.size(), bus.mem_read, cpu_complete);
    end
  endtask

  task automatic test_read_miss();
    for (int i = 0; i < 4; i++) begin
      mem[14'h0120 + 14'(i)]  = 32'hA0 + 32'(i);
      gold[14'h0120 + 14'(i)] = 32'hA0 + 32'(i);
    end
    run_req(14'h0123, 1'b0, 32'h0);
    n_checks++;
    if (cpu_read_data !== 32'hA3) begin
      n_fails++;
      $display("FAIL miss_data: got %h expected a3", cpu_read_data);
    end
    n_checks++;
    if (tag_mem[8] !== 8'h04 || st_mem[8] !== 2'd1) begin
      n_fails++;
      $display("FAIL miss_tag: got tag=%h st=%0d expected tag=04 st=1", tag_mem[8], st_mem[8]);
    end
  endtask

  task automatic test_read_hit();
    run_req(14'h0121, 1'b0, 32'h0);
    n_checks++;
    if (cpu_read_data !== 32'hA1 || bus_log.size() != 0) begin
      n_fails++;
      $display("FAIL hit_read: got %h with %0d bus words expected a1 with 0", cpu_read_data, bus_log.size());
    end
  endtask

  task automatic test_write_hit();
    run_req(14'h0122, 1'b1, 32'hDEADBEEF);
    n_checks++;
    if (st_mem[8] !== 2'd2 || data_arr[6'd34] !== 32'hDEADBEEF || bus_log.size() != 0) begin
      n_fails++;
      $display("FAIL write_hit: got st=%0d word=%h bus=%0d expected st=2 word=deadbeef bus=0",
               st_mem[8], data_arr[6'd34], bus_log.size());
    end
    n_checks++;
    if (cpu_read_data !== 32'hA1) begin
      n_fails++;
      $display("FAIL write_hold_read_data: got %h expected a1", cpu_read_data);
    end
  endtask

  task automatic test_dirty_evict();
    run_req(14'h0220, 1'b0, 32'h0);
    n_checks++;
    if (mem[14'h0122] !== 32'hDEADBEEF || mem[14'h0120] !== 32'hA0 || mem[14'h0123] !== 32'hA3) begin
      n_fails++;
      $display("FAIL evict_memory: got %h %h %h expected a0 deadbeef a3", mem[14'h0120], mem[14'h0122],
               mem[14'h0123]);
    end
    n_checks++;
    if (tag_mem[8] !== 8'h08 || st_mem[8] !== 2'd1) begin
      n_fails++;
      $display("FAIL evict_tag: got tag=%h st=%0d expected tag=08 st=1", tag_mem[8], st_mem[8]);
    end
  endtask

  task automatic test_fill_delay();
    ack_delay = 3;
    run_req(14'h0340, 1'b0, 32'h0);
    n_checks++;
    if (rd_trace.size() != 16) begin
      n_fails++;
      $display("FAIL fill_cycles: got %0d mem_read cycles expected 16", rd_trace.size());
    end
    for (int i = 0; i < 16 && i < rd_trace.size(); i++) begin
      n_checks++;
      if (rd_trace[i] !== 14'h0340 + 14'(i / 4)) begin
        n_fails++;
        $display("FAIL fill_hold cycle %0d: got %h expected %h", i, rd_trace[i], 14'h0340 + 14'(i / 4));
      end
    end
    ack_delay = 0;
  endtask

  task automatic test_reset_in_fill();
    int          cycles;
    int          wt0;
    logic [13:0] a;
    ack_delay = 0;
    wt0 = wt_count;
    bus_log.delete();
    cpu_address = 14'h0154;
    cpu_read    = 1'b1;
    cycles = 0;
    while (bus_log.size() < 2 && cycles < 100) begin
      step();
      cycles++;
    end
    step();
    n_checks++;
    if (bus.mem_read !== 1'b1 || bus.mem_address !== 14'h0156) begin
      n_fails++;
      $display("FAIL abort_setup: got mem_read=%b addr=%h expected 1 0156", bus.mem_read, bus.mem_address);
    end
    reset    = 1'b1;
    cpu_read = 1'b0;
    #1;
    n_checks++;
    if ({cpu_complete, write_tag, write_state, data_write, bus.mem_read, bus.mem_write} !== 6'b0) begin
      n_fails++;
      $display("FAIL abort_strobes: got %b expected 000000",
               {cpu_complete, write_tag, write_state, data_write, bus.mem_read, bus.mem_write});
    end
    step();
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || cpu_read_data !== 32'h0) begin
      n_fails++;
      $display("FAIL abort_idle: got mem_read=%b mem_write=%b read_data=%h expected 0 0 0",
               bus.mem_read, bus.mem_write, cpu_read_data);
    end
    n_checks++;
    if (wt_count != wt0) begin
      n_fails++;
      $display("FAIL abort_write_tag: got %0d tag writes expected %0d", wt_count, wt0);
    end
    // Tag unit was reset too: every line is invalid and unwritten dirty data is lost.
    for (int i = 0; i < 16; i++) begin
      if (cvalid[i] && cdirty[i]) begin
        for (int w = 0; w < 4; w++) begin
          a = {ctag[i], 4'(i), w[1:0]};
          gold[a] = mem[a];
        end
      end
      cvalid[i] = 1'b0;
      cdirty[i] = 1'b0;
    end
    last_read = '0;
    step();
    run_req(14'h0154, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    logic [13:0] addr;
    for (int n = 0; n < 40; n++) begin
      ack_delay = $urandom_range(0, 2);
      addr = {8'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      run_req(addr, 1'($urandom_range(0, 1)), $urandom);
    end
    ack_delay = 0;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i]  = $urandom;
      gold[i] = mem[i];
    end
    for (int i = 0; i < 16; i++) begin
      tag_mem[i] = '0;
      ctag[i]    = '0;
      cvalid[i]  = 1'b0;
      cdirty[i]  = 1'b0;
    end
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_dirty_evict();
    test_fill_delay();
    test_reset_in_fill();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
